// File: rtl/orion_types.sv
// Shared types for the front end: execute->fetch redirect, fetch->decode handoff,
// and the {pc, instr} entry held in the prefetch queue.
package orion_types;

    localparam int XLEN  = 32;
    localparam int DATAW = 32;
    localparam int ADDRW = 32;

    typedef struct packed {
        logic            jump_en;
        logic [XLEN-1:0] jump_addr;
    } ex_if_t;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [DATAW-1:0] instr;
        logic             valid;
    } if_id_t;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [DATAW-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through queue: data_o shows the head whenever empty_o is low.
// Flush wins over push and pop; push into a full queue is accepted only alongside a pop.
module fetch_fifo
    import orion_types::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  T                           data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output T                           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T              mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        empty_o  = (count_q == '0);
        full_o   = (count_q == CW'(DEPTH));
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone define which slots are live.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage: credit-limited I$ request issue, in-order response capture into a
// prefetch queue, and stale-response dropping after execute redirects.
module fetch_prefetch
    import orion_types::*;
#(
    parameter logic [XLEN-1:0] PC_RESET_ADDR   = 32'h8000_0000,
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [ADDRW-1:0] imem_addr_o,
    output logic             imem_valid_o,
    input  logic             imem_ready_i,
    input  logic [DATAW-1:0] imem_rdata_i,
    input  logic             imem_resp_i,
    input  logic             stall_i,
    input  ex_if_t           ex_if_i,
    output if_id_t           if_id_o
);

    localparam int              CW        = $clog2(FIFO_DEPTH+1);
    localparam logic [CW-1:0]   MAX_OUT_C = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]     DEPTH_C   = (CW+1)'(FIFO_DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty;
    fetch_entry_t    fifo_head, push_entry;
    logic            jump, fire, resp_keep, push, pop;
    logic [XLEN-1:0] jump_pc;

    always_comb begin
        jump      = ex_if_i.jump_en;
        jump_pc   = word_align(ex_if_i.jump_addr);
        // Credit rule: outstanding requests plus queued words never exceed the queue depth.
        imem_valid_o = !rst_i && !jump && (inflight_q < MAX_OUT_C) &&
                       (({1'b0, inflight_q} + {1'b0, fifo_count}) < DEPTH_C);
        imem_addr_o  = fetch_pc_q;
        fire         = imem_valid_o && imem_ready_i;
        resp_keep    = imem_resp_i && !jump;
        push         = resp_keep && (drop_cnt_q == '0);
        push_entry   = '{pc: resp_pc_q, instr: imem_rdata_i};
        if_id_o      = '{pc: fifo_head.pc, instr: fifo_head.instr,
                         valid: !rst_i && !fifo_empty && !jump};
        pop          = if_id_o.valid && !stall_i;

        inflight_d = inflight_q + CW'(fire) - CW'(imem_resp_i);
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_cnt_d = drop_cnt_q;
        if (jump) begin
            fetch_pc_d = jump_pc;
            resp_pc_d  = jump_pc;
            drop_cnt_d = inflight_d;
        end else begin
            if (fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (push) resp_pc_d  = resp_pc_q + XLEN'(4);
            if (resp_keep && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q <= PC_RESET_ADDR;
            resp_pc_q  <= PC_RESET_ADDR;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .flush_i (jump),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    a_push_has_slot: assert property (@(posedge clk_i) disable iff (rst_i)
        push |-> (!fifo_full || pop));

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch with an in-order I$ model of programmable latency,
// plus a constrained-random run checked against a sequential-PC scoreboard.
module tb_fetch_prefetch;
    import orion_types::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] imem_addr_o;
    logic        imem_valid_o;
    logic        imem_ready_i;
    logic [31:0] imem_rdata_i;
    logic        imem_resp_i;
    logic        stall_i;
    ex_if_t      ex_if_i;
    if_id_t      if_id_o;

    always #5 clk = ~clk;

    fetch_prefetch #(
        .PC_RESET_ADDR   (RST_PC),
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .imem_addr_o  (imem_addr_o),
        .imem_valid_o (imem_valid_o),
        .imem_ready_i (imem_ready_i),
        .imem_rdata_i (imem_rdata_i),
        .imem_resp_i  (imem_resp_i),
        .stall_i      (stall_i),
        .ex_if_i      (ex_if_i),
        .if_id_o      (if_id_o)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        pend[$];
    logic [31:0] acc_pc[$];
    logic [31:0] acc_ins[$];
    int          cyc;
    int          lat;
    bit          resp_en;
    int          n_checks;
    int          n_pass;

    logic        s_valid, s_fire, s_resp, s_out_valid;
    logic [31:0] s_addr, s_out_pc, s_out_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One clock cycle: drive the I$ response, sample mid-cycle, then advance the model at the edge.
    task automatic step();
        if (resp_en && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_i  = 1'b1;
            imem_rdata_i = mem_word(pend[0].addr);
        end else begin
            imem_resp_i  = 1'b0;
            imem_rdata_i = 32'hDEAD_BEEF;
        end
        #2;
        s_valid     = imem_valid_o;
        s_addr      = imem_addr_o;
        s_fire      = imem_valid_o && imem_ready_i;
        s_resp      = imem_resp_i;
        s_out_valid = if_id_o.valid;
        s_out_pc    = if_id_o.pc;
        s_out_instr = if_id_o.instr;
        if (s_out_valid && !stall_i) begin
            acc_pc.push_back(s_out_pc);
            acc_ins.push_back(s_out_instr);
        end
        @(posedge clk);
        if (s_resp) void'(pend.pop_front());
        if (s_fire) pend.push_back('{addr: s_addr, due: cyc + lat});
        cyc++;
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input string tag);
        rst_i             = 1'b1;
        ex_if_i.jump_en   = 1'b0;
        ex_if_i.jump_addr = '0;
        stall_i           = 1'b0;
        imem_ready_i      = 1'b1;
        resp_en           = 1'b1;
        lat               = 1;
        pend.delete();
        step();
        check({tag, "_rst_imem_valid"}, s_valid, 0);
        check({tag, "_rst_out_valid"}, s_out_valid, 0);
        step();
        rst_i = 1'b0;
        pend.delete();
        acc_pc.delete();
        acc_ins.delete();
    endtask

    task automatic jump_to(input logic [31:0] a);
        ex_if_i.jump_en   = 1'b1;
        ex_if_i.jump_addr = a;
    endtask

    task automatic no_jump();
        ex_if_i.jump_en = 1'b0;
    endtask

    int          n_f;
    int          n_bad;
    int          viol;
    int          n_acc;
    logic [31:0] exp_pc;
    logic [31:0] ja;
    bit          jmp;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        rst_i    = 1'b1;
        imem_ready_i = 1'b1;
        imem_resp_i  = 1'b0;
        imem_rdata_i = '0;
        stall_i      = 1'b0;
        ex_if_i      = '0;
        resp_en      = 1'b1;
        lat          = 1;
        @(negedge clk);

        // Test 1: zero-wait I$, one instruction per cycle, first output two cycles after first fire.
        do_reset("t1");
        step();
        check("t1_c0_valid", s_valid, 1);
        check("t1_c0_addr", s_addr, RST_PC);
        step();
        check("t1_c1_addr", s_addr, RST_PC + 4);
        check("t1_c1_out_valid", s_out_valid, 0);
        step();
        check("t1_c2_out_valid", s_out_valid, 1);
        check("t1_c2_out_pc", s_out_pc, RST_PC);
        check("t1_c2_out_instr", s_out_instr, mem_word(RST_PC));
        step();
        check("t1_c3_out_pc", s_out_pc, RST_PC + 4);
        step();
        check("t1_c4_out_pc", s_out_pc, RST_PC + 8);
        check("t1_c4_out_instr", s_out_instr, mem_word(RST_PC + 8));

        // Test 2: decode stalled for 10 cycles; issue stops after 4 fires, stream resumes without gaps.
        do_reset("t2");
        stall_i = 1'b1;
        n_f = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_fire) n_f++;
        end
        check("t2_fires", n_f, 4);
        check("t2_valid_after_fill", s_valid, 0);
        check("t2_head_held_valid", s_out_valid, 1);
        check("t2_head_held_pc", s_out_pc, RST_PC);
        stall_i = 1'b0;
        steps(12);
        check("t2_n_out", acc_pc.size() >= 6, 1);
        if (acc_pc.size() >= 6) begin
            n_bad = 0;
            for (int i = 0; i < 6; i++)
                if (acc_pc[i] !== RST_PC + 32'(4 * i) || acc_ins[i] !== mem_word(acc_pc[i])) n_bad++;
            check("t2_seq_errs", n_bad, 0);
        end

        // Test 3: two requests (0x..08, 0x..0C) in flight at the redirect; both responses dropped.
        do_reset("t3");
        steps(2);
        step();
        check("t3_c2_addr", s_addr, RST_PC + 8);
        resp_en = 1'b0;
        step();
        check("t3_c3_fire", s_fire, 1);
        check("t3_c3_addr", s_addr, RST_PC + 12);
        jump_to(32'h8000_0100);
        step();
        check("t3_jump_valid", s_valid, 0);
        check("t3_drop_cnt", dut.drop_cnt_q, 2);
        no_jump();
        resp_en = 1'b1;
        acc_pc.delete();
        acc_ins.delete();
        steps(10);
        check("t3_n_out", acc_pc.size() >= 2, 1);
        if (acc_pc.size() >= 2) begin
            check("t3_first_pc", acc_pc[0], 32'h8000_0100);
            check("t3_first_instr", acc_ins[0], mem_word(32'h8000_0100));
            check("t3_second_pc", acc_pc[1], 32'h8000_0104);
        end

        // Test 4: redirect coincides with a response while ready is low.
        do_reset("t4");
        lat = 2;
        steps(2);
        jump_to(32'h8000_0100);
        imem_ready_i = 1'b0;
        step();
        check("t4_jump_valid", s_valid, 0);
        check("t4_jump_out_valid", s_out_valid, 0);
        check("t4_drop_cnt", dut.drop_cnt_q, 1);
        no_jump();
        imem_ready_i = 1'b1;
        acc_pc.delete();
        acc_ins.delete();
        step();
        check("t4_next_valid", s_valid, 1);
        check("t4_next_addr", s_addr, 32'h8000_0100);
        check("t4_drop_cnt_after", dut.drop_cnt_q, 0);
        steps(8);
        check("t4_n_out", acc_pc.size() >= 1, 1);
        if (acc_pc.size() >= 1) begin
            check("t4_first_pc", acc_pc[0], 32'h8000_0100);
            check("t4_first_instr", acc_ins[0], mem_word(32'h8000_0100));
        end

        // Test 5: back-to-back redirects with a stalled, non-empty queue; unaligned second target.
        do_reset("t5");
        steps(4);
        stall_i = 1'b1;
        steps(3);
        jump_to(32'h8000_0100);
        step();
        check("t5_j1_out_valid", s_out_valid, 0);
        jump_to(32'h8000_0203);
        step();
        check("t5_j2_valid", s_valid, 0);
        check("t5_j2_out_valid", s_out_valid, 0);
        no_jump();
        stall_i = 1'b0;
        acc_pc.delete();
        acc_ins.delete();
        steps(12);
        check("t5_n_out", acc_pc.size() >= 3, 1);
        n_bad = 0;
        foreach (acc_pc[i])
            if (acc_pc[i] >= 32'h8000_0100 && acc_pc[i] <= 32'h8000_01FF) n_bad++;
        check("t5_stale_100_entries", n_bad, 0);
        if (acc_pc.size() >= 3) begin
            check("t5_first_pc", acc_pc[0], 32'h8000_0200);
            check("t5_third_pc", acc_pc[2], 32'h8000_0208);
            check("t5_third_instr", acc_ins[2], mem_word(32'h8000_0208));
        end

        // Test 6: pc arithmetic wraps modulo 2^32.
        do_reset("t6");
        step();
        jump_to(32'hFFFF_FFF8);
        step();
        no_jump();
        acc_pc.delete();
        acc_ins.delete();
        steps(10);
        check("t6_n_out", acc_pc.size() >= 3, 1);
        if (acc_pc.size() >= 3) begin
            check("t6_pc0", acc_pc[0], 32'hFFFF_FFF8);
            check("t6_pc1", acc_pc[1], 32'hFFFF_FFFC);
            check("t6_pc2_wrap", acc_pc[2], 32'h0000_0000);
            check("t6_instr2", acc_ins[2], mem_word(32'h0000_0000));
        end

        // Test 7: random ready, latency, stalls and redirects against a sequential-PC scoreboard.
        do_reset("t7");
        exp_pc = RST_PC;
        n_bad  = 0;
        viol   = 0;
        n_acc  = 0;
        for (int i = 0; i < 3000; i++) begin
            imem_ready_i = ($urandom_range(3) != 0);
            stall_i      = ($urandom_range(3) == 0);
            lat          = $urandom_range(5);
            jmp          = ($urandom_range(39) == 0);
            ja           = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
            if (jmp) jump_to(ja);
            else     no_jump();
            acc_pc.delete();
            acc_ins.delete();
            step();
            foreach (acc_pc[k]) begin
                if (acc_pc[k] !== exp_pc || acc_ins[k] !== mem_word(exp_pc)) n_bad++;
                exp_pc = exp_pc + 4;
                n_acc++;
            end
            if (jmp) exp_pc = {ja[31:2], 2'b00};
            if (dut.inflight_q > 2 || (32'(dut.inflight_q) + 32'(dut.fifo_count)) > 4) viol++;
        end
        no_jump();
        check("t7_scoreboard_errs", n_bad, 0);
        check("t7_bound_violations", viol, 0);
        check("t7_progress", n_acc > 500, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
